// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and helpers for the UART transmit arbiter
//
// Holds the FSM state encoding, the byte width and a constant clog2 helper
// used to size pointers and timers.
package uart_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  localparam int BYTE_W = 8;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search
//
// Ports:
//   valid_i  candidate request vector
//   ptr_i    index with highest priority this cycle
//   found_o  at least one candidate is valid
//   idx_o    first valid index scanning ptr_i, ptr_i+1, ... modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] j;

  // Scan from the farthest position back toward ptr_i so the closest valid
  // candidate is the last one written and therefore wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr_i) + k) % N);
      if (valid_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one UART transmitter
//
// Ports:
//   CLOCK_50   system clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester byte available
//   req_data   per-requester byte, requester i at [8i+7:8i]
//   req_last   per-requester final-byte-of-packet flag
//   req_ready  per-requester byte accepted this cycle
//   tx_start   one-cycle start pulse to the transmitter
//   tx_data    byte being transmitted
//   tx_busy    transmitter busy
//   grant      one-hot current owner, 0 when unowned
//   timeout    one-cycle pulse when an idle owner loses its lock
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int HOLD_TIMEOUT = 50000
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic [NREQ-1:0]          grant,
  output logic                     timeout
);

  localparam int IW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam int TW = (clog2(HOLD_TIMEOUT) < 1) ? 1 : clog2(HOLD_TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              last_q, last_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              timeout_q, timeout_d;

  logic              found;
  logic [IW-1:0]     win;
  logic [NREQ-1:0]   win_onehot;
  logic [IW-1:0]     sel_idx;
  logic [BYTE_W-1:0] sel_data;
  logic              sel_last;
  logic [IW-1:0]     next_ptr;
  logic [NREQ-1:0]   ready_c;
  logic [NREQ-1:0]   owner_valid;

  rr_pick #(.N(NREQ), .W(IW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (found),
    .idx_o   (win)
  );

  // In HOLD the byte always comes from the locked owner; otherwise from the
  // round-robin winner.
  assign sel_idx     = (state_q == ST_HOLD) ? owner_q : win;
  assign owner_valid = grant_q & req_valid;
  assign next_ptr    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    sel_data   = '0;
    sel_last   = 1'b0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == sel_idx) begin
        sel_data = req_data[i*BYTE_W +: BYTE_W];
        sel_last = req_last[i];
      end
      win_onehot[i] = (IW'(i) == win);
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    ready_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          ready_c   = win_onehot;
          tx_data_d = sel_data;
          last_d    = sel_last;
          grant_d   = win_onehot;
          owner_d   = win;
          state_d   = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (tx_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end else begin
            timer_d  = '0;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A byte arriving on the final timer cycle still beats the timeout.
        if (|owner_valid) begin
          ready_c   = owner_valid;
          tx_data_d = sel_data;
          last_d    = sel_last;
          state_d   = ST_START;
        end else if (timer_q == TW'(HOLD_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          rr_ptr_d  = next_ptr;
          state_d   = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  // Ready is combinational, so it must be masked while reset is held.
  assign req_ready = rst ? '0 : ready_c;
  assign tx_start  = (state_q == ST_START);
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        timeout;

  int busy_cnt = 0;
  int to_cnt = 0;
  logic [7:0] log_data[$];
  logic [3:0] log_grant[$];

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int         r;
    logic [7:0] d;
    logic       l;
  } item_t;
  item_t pend[$];
  int    order[$];
  int    multi_cnt;

  uart_tx_arbiter #(.NREQ(4), .HOLD_TIMEOUT(16)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant     (grant),
    .timeout   (timeout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Transmitter model: busy for 4 cycles starting the cycle after a start.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge CLOCK_50) begin
    if (tx_start) busy_cnt <= 4;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (tx_start) begin
      log_data.push_back(tx_data);
      log_grant.push_back(grant);
    end
    if (timeout) to_cnt <= to_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Presents the head of each requester's pending list every cycle and
  // removes it when accepted, until all are sent and the grant is released.
  task automatic run_queue(input int max_cyc, output bit done);
    done = 1'b0;
    order.delete();
    multi_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge CLOCK_50);
      req_valid = '0;
      req_last  = '0;
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < pend.size(); i++) begin
          if (pend[i].r == r) begin
            req_valid[r] = 1'b1;
            req_data[8*r +: 8] = pend[i].d;
            req_last[r] = pend[i].l;
            break;
          end
        end
      end
      #1;
      if ($countones(req_ready) > 1) multi_cnt++;
      for (int r = 0; r < 4; r++) begin
        if (req_ready[r]) begin
          order.push_back(r);
          for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].r == r) begin
              pend.delete(i);
              break;
            end
          end
        end
      end
      if (pend.size() == 0 && req_valid == 4'b0 && grant == 4'b0) begin
        done = 1'b1;
        break;
      end
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    req_last = '0;
    repeat (3) @(negedge CLOCK_50);
    #1;
    tests_run++; if (req_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tests_run++; if (grant !== 4'b0) begin tests_failed++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    tests_run++; if (tx_start !== 1'b0 || timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses got start=%b timeout=%b exp=0,0", tx_start, timeout); end
    tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    @(negedge CLOCK_50);
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single_byte();
    int base;
    base = log_data.size();
    @(negedge CLOCK_50);
    req_valid = 4'b0100;
    req_data[23:16] = 8'h41;
    req_last = 4'b0100;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    @(negedge CLOCK_50);
    req_valid = '0;
    req_last = '0;
    #1;
    tests_run++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin tests_failed++; $display("FAIL single_start got start=%b data=%h exp=1,41", tx_start, tx_data); end
    tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL single_grant got=%b exp=0100", grant); end
    tests_run++; if (req_ready !== 4'b0) begin tests_failed++; $display("FAIL single_ready_start got=%b exp=0000", req_ready); end
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK_50);
      if (grant == 4'b0) break;
    end
    tests_run++; if (grant !== 4'b0) begin tests_failed++; $display("FAIL single_release got=%b exp=0000", grant); end
    tests_run++; if (log_data.size() - base !== 1) begin tests_failed++; $display("FAIL single_start_count got=%0d exp=1", log_data.size() - base); end
  endtask

  // After requester 2's packet the pointer sits at 3, so 3 beats 0.
  task automatic test_rr_pointer();
    bit done;
    int base;
    base = log_data.size();
    pend.push_back('{0, 8'h05, 1'b1});
    pend.push_back('{3, 8'h53, 1'b1});
    run_queue(200, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL rr_done got=0 exp=1"); end
    tests_run++;
    if (order.size() !== 2) begin tests_failed++; $display("FAIL rr_order_len got=%0d exp=2", order.size()); end
    else if (order[0] !== 3 || order[1] !== 0) begin tests_failed++; $display("FAIL rr_order got=%0d,%0d exp=3,0", order[0], order[1]); end
    tests_run++;
    if (log_data.size() - base !== 2) begin tests_failed++; $display("FAIL rr_log_len got=%0d exp=2", log_data.size() - base); end
    else if (log_data[base] !== 8'h53 || log_data[base+1] !== 8'h05) begin tests_failed++; $display("FAIL rr_data got=%h,%h exp=53,05", log_data[base], log_data[base+1]); end
  endtask

  task automatic test_simultaneous();
    bit done;
    int base;
    logic [7:0] exp_d[5];
    logic [3:0] exp_g[5];
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    base = log_data.size();
    pend.push_back('{0, 8'hA0, 1'b1});
    pend.push_back('{1, 8'hA1, 1'b1});
    pend.push_back('{2, 8'hA2, 1'b1});
    pend.push_back('{3, 8'hA3, 1'b1});
    pend.push_back('{0, 8'hB0, 1'b1});
    run_queue(400, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL simul_done got=0 exp=1"); end
    tests_run++; if (multi_cnt !== 0) begin tests_failed++; $display("FAIL simul_onehot_ready got=%0d multi-ready cycles exp=0", multi_cnt); end
    tests_run++;
    if (log_data.size() - base !== 5) begin tests_failed++; $display("FAIL simul_start_count got=%0d exp=5", log_data.size() - base); end
    else begin
      for (int i = 0; i < 5; i++) begin
        if (log_data[base+i] !== exp_d[i] || log_grant[base+i] !== exp_g[i]) begin
          tests_failed++;
          $display("FAIL simul_byte%0d got data=%h grant=%b exp data=%h grant=%b", i, log_data[base+i], log_grant[base+i], exp_d[i], exp_g[i]);
          break;
        end
      end
    end
  endtask

  // Pointer is 1 here: requester 1's three-byte packet must finish before 0.
  task automatic test_packet_lock();
    bit done;
    int base;
    logic [7:0] exp_d[4];
    int exp_o[4];
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h20};
    exp_o = '{1, 1, 1, 0};
    base = log_data.size();
    pend.push_back('{0, 8'h20, 1'b1});
    pend.push_back('{1, 8'h10, 1'b0});
    pend.push_back('{1, 8'h11, 1'b0});
    pend.push_back('{1, 8'h12, 1'b1});
    run_queue(400, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL lock_done got=0 exp=1"); end
    tests_run++;
    if (order.size() !== 4) begin tests_failed++; $display("FAIL lock_order_len got=%0d exp=4", order.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        if (order[i] !== exp_o[i]) begin
          tests_failed++;
          $display("FAIL lock_order%0d got=%0d exp=%0d", i, order[i], exp_o[i]);
          break;
        end
      end
    end
    tests_run++;
    if (log_data.size() - base !== 4) begin tests_failed++; $display("FAIL lock_start_count got=%0d exp=4", log_data.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        if (log_data[base+i] !== exp_d[i]) begin
          tests_failed++;
          $display("FAIL lock_byte%0d got=%h exp=%h", i, log_data[base+i], exp_d[i]);
          break;
        end
      end
    end
  endtask

  // Sends one non-last byte from requester 3; leaves the bench at the
  // negedge of the start cycle S.
  task automatic send_open_byte(input logic [7:0] d, input string tag);
    @(negedge CLOCK_50);
    req_valid = 4'b1000;
    req_data[31:24] = d;
    req_last = 4'b0000;
    #1;
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL %s_ready got=%b exp=1000", tag, req_ready); end
    @(negedge CLOCK_50);
    req_valid = '0;
    #1;
    tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("FAIL %s_start got=%b exp=1", tag, tx_start); end
  endtask

  // HOLD is entered at S+6, so with a 16-cycle limit the pulse lands at S+22.
  task automatic test_timeout();
    bit done;
    int early;
    int base_to;
    base_to = to_cnt;
    early = 0;
    send_open_byte(8'h33, "tmo");
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLOCK_50);
      if (timeout !== 1'b0) early++;
    end
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL tmo_early got=%0d early pulses exp=0", early); end
    @(negedge CLOCK_50);
    tests_run++; if (timeout !== 1'b1 || grant !== 4'b0) begin tests_failed++; $display("FAIL tmo_pulse got timeout=%b grant=%b exp=1,0000", timeout, grant); end
    @(negedge CLOCK_50);
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_width got=%b exp=0", timeout); end
    tests_run++; if (to_cnt - base_to !== 1) begin tests_failed++; $display("FAIL tmo_count got=%0d exp=1", to_cnt - base_to); end
    pend.push_back('{2, 8'h52, 1'b1});
    pend.push_back('{0, 8'h50, 1'b1});
    run_queue(200, done);
    tests_run++;
    if (!done || order.size() !== 2) begin tests_failed++; $display("FAIL tmo_next got done=%0d len=%0d exp=1,2", done, order.size()); end
    else if (order[0] !== 0 || order[1] !== 2) begin tests_failed++; $display("FAIL tmo_next_order got=%0d,%0d exp=0,2", order[0], order[1]); end
  endtask

  task automatic test_timeout_race();
    int base_to;
    base_to = to_cnt;
    send_open_byte(8'h60, "race");
    repeat (20) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    req_valid = 4'b1000;
    req_data[31:24] = 8'h61;
    req_last = 4'b1000;
    #1;
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL race_ready got=%b exp=1000", req_ready); end
    @(negedge CLOCK_50);
    req_valid = '0;
    req_last = '0;
    #1;
    tests_run++; if (timeout !== 1'b0 || tx_start !== 1'b1 || tx_data !== 8'h61) begin tests_failed++; $display("FAIL race_start got timeout=%b start=%b data=%h exp=0,1,61", timeout, tx_start, tx_data); end
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK_50);
      if (grant == 4'b0) break;
    end
    tests_run++; if (grant !== 4'b0 || to_cnt !== base_to) begin tests_failed++; $display("FAIL race_end got grant=%b timeouts=%0d exp=0000,0", grant, to_cnt - base_to); end
  endtask

  task automatic test_reset_mid();
    bit done;
    int base;
    @(negedge CLOCK_50);
    req_valid = 4'b0100;
    req_data[23:16] = 8'h70;
    req_last = 4'b0000;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL rmid_ready got=%b exp=0100", req_ready); end
    @(negedge CLOCK_50);
    req_data[23:16] = 8'h71;
    req_last = 4'b0100;
    tests_run++; if (tx_start !== 1'b1) begin tests_failed++; $display("FAIL rmid_start got=%b exp=1", tx_start); end
    repeat (2) @(negedge CLOCK_50);
    rst = 1'b1;
    #1;
    tests_run++; if (grant !== 4'b0 || tx_start !== 1'b0 || req_ready !== 4'b0) begin tests_failed++; $display("FAIL rmid_clear got grant=%b start=%b ready=%b exp=0000,0,0000", grant, tx_start, req_ready); end
    tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL rmid_tx_data got=%h exp=00", tx_data); end
    base = log_data.size();
    @(negedge CLOCK_50);
    rst = 1'b0;
    req_valid = '0;
    req_last = '0;
    repeat (3) @(negedge CLOCK_50);
    tests_run++; if (log_data.size() !== base) begin tests_failed++; $display("FAIL rmid_no_start got=%0d starts exp=0", log_data.size() - base); end
    pend.push_back('{2, 8'h72, 1'b1});
    pend.push_back('{0, 8'h80, 1'b1});
    run_queue(200, done);
    tests_run++;
    if (!done || order.size() !== 2) begin tests_failed++; $display("FAIL rmid_next got done=%0d len=%0d exp=1,2", done, order.size()); end
    else if (order[0] !== 0 || order[1] !== 2) begin tests_failed++; $display("FAIL rmid_order got=%0d,%0d exp=0,2", order[0], order[1]); end
    tests_run++;
    if (log_data.size() - base !== 2) begin tests_failed++; $display("FAIL rmid_start_count got=%0d exp=2", log_data.size() - base); end
    else if (log_data[base] !== 8'h80 || log_data[base+1] !== 8'h72) begin tests_failed++; $display("FAIL rmid_data got=%h,%h exp=80,72", log_data[base], log_data[base+1]); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_rr_pointer();
    test_simultaneous();
    test_packet_lock();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
